// File: rtl/fetch_seq_ctl_if.sv
// Instruction-memory fetch bus between the fetch sequencer and the
// instruction memory.
//   fetch_addr : PC of the outstanding fetch (sequencer -> memory)
//   fetch_req  : fetch request (sequencer -> memory)
//   imem_ready : memory returns the word for fetch_addr this cycle (memory -> sequencer)
interface fetch_seq_ctl_if;
    logic [31:0] fetch_addr;
    logic        fetch_req;
    logic        imem_ready;

    modport master (
        output fetch_addr,
        output fetch_req,
        input  imem_ready
    );

    modport slave (
        input  fetch_addr,
        input  fetch_req,
        output imem_ready
    );
endinterface

// File: rtl/fetch_seq_ctl.sv
// Fetch sequencer for a 5-stage pipeline: advances the PC, applies
// branch/jump redirects resolved in ID, drains an in-flight fetch when a
// redirect arrives before memory has answered, and halts on a halting
// syscall. Also counts resolved and taken conditional branches.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   imem              : fetch bus (fetch_addr, fetch_req out; imem_ready in)
//   stall             : ID load-use stall, holds PC and IF/ID
//   id_valid          : ID holds a real instruction
//   id_is_branch      : ID instruction is a conditional branch
//   id_branch_taken   : branch decision for the ID instruction
//   id_branch_target  : branch target address
//   id_is_jump        : ID instruction is a jump
//   id_jump_target    : jump target address
//   halt_req          : ID instruction is a halting syscall
//   ifid_we           : IF/ID write enable
//   ifid_flush        : IF/ID clear to bubble (overrides ifid_we)
//   halted            : controller is in HALT
//   branch_cnt        : resolved conditional branch count (wraps)
//   taken_cnt         : taken conditional branch count (wraps)
module fetch_seq_ctl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fetch_seq_ctl_if.master        imem,
    input  logic                   stall,
    input  logic                   id_valid,
    input  logic                   id_is_branch,
    input  logic                   id_branch_taken,
    input  logic [31:0]            id_branch_target,
    input  logic                   id_is_jump,
    input  logic [31:0]            id_jump_target,
    input  logic                   halt_req,
    output logic                   ifid_we,
    output logic                   ifid_flush,
    output logic                   halted,
    output logic [15:0]            branch_cnt,
    output logic [15:0]            taken_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pending_q, pending_d;
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    logic        halt_take;
    logic        redirect;
    logic        count_br;
    logic [31:0] target;

    assign halt_take = id_valid & halt_req;
    assign redirect  = id_valid & ~stall & (id_is_jump | (id_is_branch & id_branch_taken));
    // Jump wins over branch when both are flagged; targets are word aligned.
    assign target    = {(id_is_jump ? id_jump_target[31:2] : id_branch_target[31:2]), 2'b00};
    assign count_br  = (state_q == RUN) & id_valid & id_is_branch & ~stall & ~halt_req;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            addr_q       <= RESET_PC;
            pending_q    <= 32'h0;
            branch_cnt_q <= 16'h0;
            taken_cnt_q  <= 16'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pending_q    <= pending_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pending_d    = pending_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;

        // Counting is independent of the redirect path, so a branch that is
        // also flagged as a jump still counts.
        if (count_br) begin
            branch_cnt_d = branch_cnt_q + 16'd1;
            if (id_branch_taken) begin
                taken_cnt_d = taken_cnt_q + 16'd1;
            end
        end

        unique case (state_q)
            RUN: begin
                if (halt_take) begin
                    state_d = HALT;
                end else if (stall) begin
                    state_d = RUN;
                end else if (redirect) begin
                    if (imem.imem_ready) begin
                        addr_d = target;
                    end else begin
                        // The wrong-path fetch is still outstanding; let it
                        // complete before switching the address.
                        pending_d = target;
                        state_d   = DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    addr_d = addr_q + 32'd4;
                end
            end
            DRAIN: begin
                if (imem.imem_ready) begin
                    addr_d  = pending_q;
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        if (rst_n && (state_q == RUN) && !halt_take && !stall) begin
            if (redirect) begin
                ifid_flush = 1'b1;
            end else if (imem.imem_ready) begin
                ifid_we = 1'b1;
            end
        end
    end

    assign imem.fetch_addr = addr_q;
    assign imem.fetch_req  = (state_q != HALT);
    assign halted          = (state_q == HALT);
    assign branch_cnt      = branch_cnt_q;
    assign taken_cnt       = taken_cnt_q;

endmodule

// File: tb/tb_fetch_seq_ctl.sv
// Scoreboard bench for fetch_seq_ctl: the stimulus process pushes the
// hand-computed outputs expected in each driven cycle; a monitor pops and
// compares them at the falling edge.
module tb_fetch_seq_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        id_valid;
    logic        id_is_branch;
    logic        id_branch_taken;
    logic [31:0] id_branch_target;
    logic        id_is_jump;
    logic [31:0] id_jump_target;
    logic        halt_req;
    logic        ifid_we;
    logic        ifid_flush;
    logic        halted;
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;

    fetch_seq_ctl_if bus ();

    fetch_seq_ctl #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (bus.master),
        .stall            (stall),
        .id_valid         (id_valid),
        .id_is_branch     (id_is_branch),
        .id_branch_taken  (id_branch_taken),
        .id_branch_target (id_branch_target),
        .id_is_jump       (id_is_jump),
        .id_jump_target   (id_jump_target),
        .halt_req         (halt_req),
        .ifid_we          (ifid_we),
        .ifid_flush       (ifid_flush),
        .halted           (halted),
        .branch_cnt       (branch_cnt),
        .taken_cnt        (taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic        we;
        logic        flush;
        logic        req;
        logic        hlt;
        logic [15:0] bc;
        logic [15:0] tc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: one expected entry per checked cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.fetch_addr !== e.addr || ifid_we !== e.we || ifid_flush !== e.flush ||
                bus.fetch_req !== e.req || halted !== e.hlt ||
                branch_cnt !== e.bc || taken_cnt !== e.tc) begin
                n_err++;
                $display("FAIL %s: got addr=%h we=%b flush=%b req=%b halted=%b bc=%h tc=%h, expected addr=%h we=%b flush=%b req=%b halted=%b bc=%h tc=%h",
                         e.nm, bus.fetch_addr, ifid_we, ifid_flush, bus.fetch_req, halted,
                         branch_cnt, taken_cnt, e.addr, e.we, e.flush, e.req, e.hlt, e.bc, e.tc);
            end
        end
    end

    task automatic set_id(input logic v, input logic br, input logic tk, input logic [31:0] bt,
                          input logic jp, input logic [31:0] jt, input logic hr);
        id_valid         = v;
        id_is_branch     = br;
        id_branch_taken  = tk;
        id_branch_target = bt;
        id_is_jump       = jp;
        id_jump_target   = jt;
        halt_req         = hr;
    endtask

    task automatic clr_id();
        set_id(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        stall = 1'b0;
    endtask

    // Queue the outputs expected with the inputs already driven, then advance.
    task automatic cyc(input string nm, input logic [31:0] a, input logic we, input logic fl,
                       input logic rq, input logic hl, input logic [15:0] bc, input logic [15:0] tc);
        exp_t e;
        e.nm = nm; e.addr = a; e.we = we; e.flush = fl; e.req = rq; e.hlt = hl; e.bc = bc; e.tc = tc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.imem_ready = 1'b0;
        clr_id();
        @(posedge clk);
        #1;

        // Reset cycle: writes suppressed even with memory ready and a taken branch.
        bus.imem_ready = 1'b1;
        set_id(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        cyc("reset", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        rst_n = 1'b1;
        clr_id();

        // Sequential fetch
        cyc("seq0", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        cyc("seq4", 32'h4, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        cyc("seq8", 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        cyc("seqC", 32'hC, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);

        // Taken BEQ with memory ready
        set_id(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        cyc("beq", 32'h10, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
        clr_id();
        cyc("beq_tgt", 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1, 16'h1);

        // Not-taken BNE, then stalled taken BGTZ
        set_id(1'b1, 1'b1, 1'b0, 32'h999, 1'b0, 32'h0, 1'b0);
        cyc("bne", 32'h44, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1, 16'h1);
        set_id(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        stall = 1'b1;
        cyc("stall0", 32'h48, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2, 16'h1);
        cyc("stall1", 32'h48, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2, 16'h1);
        stall = 1'b0;
        cyc("bgtz", 32'h48, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2, 16'h1);
        clr_id();
        cyc("bgtz_tgt", 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3, 16'h2);

        // JR to unaligned 0x103 while memory is busy -> DRAIN
        bus.imem_ready = 1'b0;
        set_id(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h103, 1'b0);
        cyc("jr", 32'h84, 1'b0, 1'b1, 1'b1, 1'b0, 16'h3, 16'h2);
        set_id(1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1);
        cyc("drain0", 32'h84, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3, 16'h2);
        stall = 1'b1;
        cyc("drain1", 32'h84, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3, 16'h2);
        clr_id();
        bus.imem_ready = 1'b1;
        cyc("drain_end", 32'h84, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3, 16'h2);
        bus.imem_ready = 1'b0;
        cyc("jr_tgt", 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3, 16'h2);

        // Jump and branch both flagged: jump target, branch still counted
        bus.imem_ready = 1'b1;
        set_id(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0);
        cyc("jmp_br", 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 16'h3, 16'h2);
        clr_id();
        bus.imem_ready = 1'b0;
        cyc("jmp_br_tgt", 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4, 16'h3);

        // Halt, inputs ignored in HALT, reset exits
        bus.imem_ready = 1'b1;
        set_id(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        cyc("halt_req", 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4, 16'h3);
        set_id(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        cyc("halted0", 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4, 16'h3);
        cyc("halted1", 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4, 16'h3);
        clr_id();
        rst_n = 1'b0;
        cyc("halt_rst", 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4, 16'h3);
        rst_n = 1'b1;
        bus.imem_ready = 1'b0;
        cyc("post_rst", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);

        // Address wrap at top of memory
        bus.imem_ready = 1'b1;
        set_id(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cyc("jmp_top", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
        clr_id();
        cyc("top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        bus.imem_ready = 1'b0;
        cyc("addr_wrap", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);

        // Counter wrap: 65535 unchecked taken branches, then the 65536th
        bus.imem_ready = 1'b1;
        set_id(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        cyc("cnt_ffff", 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        clr_id();
        bus.imem_ready = 1'b0;
        cyc("cnt_wrap", 32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
